muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised RV64IM M-extension execute unit for the pipelined CPU: decodes func3 plus the word-op flag and sequences multiply and divide/remainder operations.
- Multiplies have a fixed latency; divides use an iterative one-bit-per-cycle restoring divider.
- Sits beside the main ALU in EX. The hazard unit stalls the pipeline with busy and captures result on done.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- MUL_STAGES, 2, multiply latency in cycles (1..4).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  launch operation (sampled only in IDLE)
- func3  input  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_w  input  1  RV64 word variant (MULW/DIVW/DIVUW/REMW/REMUW)
- flush  input  1  abort the in-flight operation
- a  input  XLEN  rs1 operand
- b  input  XLEN  rs2 operand
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when result is valid
- result  output  XLEN  final result, held until the next done

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0.
- States:
  - IDLE: on start && !flush, latch func3, op_w, a, b. Go to MUL when func3[2]=0, otherwise DIVCHK.
  - MUL: count MUL_STAGES cycles, then go to FIN.
  - DIVCHK: on divide-by-zero or signed overflow go to FIN with the special result. Otherwise take operand absolute values (signed ops) and go to DIV.
  - DIV: N iterations, N=XLEN (N=32 for word ops), one quotient bit per cycle, then go to FIN.
  - FIN: apply sign correction, write result, pulse done, go to IDLE.
- Latency, with start sampled at edge k:
  - MUL: done visible in cycle k+MUL_STAGES+1.
  - Normal divide: done at k+N+2.
  - Divide special cases: done at k+2.
- Handshake:
  - start is ignored while busy.
  - start may be reasserted in the same cycle done is high; it is accepted only because the state is IDLE on the following edge, i.e. one idle cycle is required between operations.
- Multiply:
  - Full 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (b==0):
  - DIV and DIVU give all ones.
  - REM and REMU give the dividend.
- Signed overflow (a = most negative, b = -1):
  - DIV gives the most negative value.
  - REM gives 0.
- flush: in any non-IDLE state, go to IDLE on the next edge with no done pulse; result keeps its previous value. If flush and start are both high in IDLE, flush wins and nothing is launched.
- rst mid-operation: immediate return to reset values on the next edge.
- done is never asserted in two consecutive cycles.

Optional Feature:
- Macro: MULDIV_WORD_EN.
- Defined (requires XLEN=64): op_w selects word ops.
  - Operands use a[31:0] and b[31:0], sign- or zero-extended per op.
  - Divide runs N=32 iterations.
  - Result is the 32-bit value sign-extended from bit 31 (including DIVUW/REMUW).
  - Special-case checks use the 32-bit operands.
  - op_w with func3 = 001/010/011 is treated as MULW.
- Undefined: op_w is ignored, all ops are full-width, and the word datapath is not synthesised.

Test Plan:
- Reset, then MUL, a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), start at cycle 0 -> busy=1 from cycle 1; done in cycle 3 (MUL_STAGES=2); result=0xFFFF_FFFF_FFFF_FFEB.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULHSU a=-1, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-20, b=3 -> done after 66 cycles, result=-6. REM with the same operands -> result=-2. DIVU a=20, b=3 -> result=6.
- DIV a=5, b=0 -> done in cycle 2, result=all ones. REM a=0x8000_0000_0000_0000, b=-1 -> done in cycle 2, result=0.
- With MULDIV_WORD_EN defined:
  - DIVW a=0x0000_0001_8000_0000, b=-1 -> result=0xFFFF_FFFF_8000_0000, done at cycle 2.
  - MULW a=0x7FFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE.
- DIV started, flush asserted at cycle 10 -> busy=0 at cycle 11, no done, result unchanged. A start during busy is ignored. rst at cycle 5 of a divide returns all outputs to 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV64IM M-extension execute unit: fixed-latency multiply plus restoring divider (one quotient bit per cycle).
// Optional word ops (MULW/DIVW/DIVUW/REMW/REMUW) are built when MULDIV_WORD_EN is defined; this requires XLEN=64.
module muldiv_unit #(
    parameter int XLEN       = 64,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic            op_w,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    // state  | meaning
    // IDLE   | waiting for start
    // MUL    | multiply latency countdown
    // DIVCHK | special-case detection, operand magnitudes
    // DIV    | one restoring step per cycle
    // FIN    | sign fix-up, done pulse, result capture
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIVCHK, S_DIV, S_FIN} state_t;

    localparam int CW = $clog2(XLEN + 1);

    state_t          r_state, w_next;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_a, r_b, r_div, r_q, r_rem, r_result;
    logic            r_negq, r_negr;
    logic [CW-1:0]   r_cnt;

    logic [2:0]      w_f3_in;
    logic [XLEN-1:0] w_a_in, w_b_in, w_min, w_dvd, w_fin, w_raw, w_mul_res, w_div_res;
    logic [XLEN-1:0] w_abs_a, w_abs_b;
    logic [CW-1:0]   w_div_last;
    logic            w_sdiv, w_a_neg, w_b_neg, w_bzero, w_ovf, w_special, w_sa, w_sb, w_ge;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
    logic [XLEN:0]   w_shift, w_diff;

`ifdef MULDIV_WORD_EN
    logic r_word;
    logic w_sx;

    // Word ops fold MULH* onto MULW; only unsigned divides zero-extend their operands.
    assign w_sx    = !(func3[2] && func3[0]);
    assign w_f3_in = (op_w && !func3[2]) ? 3'b000 : func3;
    assign w_a_in  = op_w ? {{(XLEN-32){w_sx & a[31]}}, a[31:0]} : a;
    assign w_b_in  = op_w ? {{(XLEN-32){w_sx & b[31]}}, b[31:0]} : b;
    assign w_min   = r_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_dvd   = r_word ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
    assign w_div_last = r_word ? CW'(31) : CW'(XLEN-1);
    assign w_fin   = r_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
`else
    logic w_unused_opw;

    assign w_unused_opw = op_w;
    assign w_f3_in    = func3;
    assign w_a_in     = a;
    assign w_b_in     = b;
    assign w_min      = {1'b1, {(XLEN-1){1'b0}}};
    assign w_dvd      = w_abs_a;
    assign w_div_last = CW'(XLEN-1);
    assign w_fin      = w_raw;
`endif

    // Multiply: sign/zero-extend to 2*XLEN so one unsigned product covers all three signednesses.
    assign w_sa      = (r_f3[1:0] == 2'b01) || (r_f3[1:0] == 2'b10);
    assign w_sb      = (r_f3[1:0] == 2'b01);
    assign w_ma      = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
    assign w_mb      = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_sdiv    = !r_f3[0];
    assign w_a_neg   = w_sdiv & r_a[XLEN-1];
    assign w_b_neg   = w_sdiv & r_b[XLEN-1];
    assign w_abs_a   = w_a_neg ? -r_a : r_a;
    assign w_abs_b   = w_b_neg ? -r_b : r_b;
    assign w_bzero   = (r_b == '0);
    assign w_ovf     = w_sdiv && (r_a == w_min) && (r_b == '1);
    assign w_special = w_bzero || w_ovf;

    // Partial remainder never exceeds 2*divisor-1, so the borrow bit alone decides the quotient bit.
    assign w_shift   = {r_rem, r_q[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_ge      = !w_diff[XLEN];

    assign w_div_res = r_f3[1] ? (r_negr ? -r_rem : r_rem) : (r_negq ? -r_q : r_q);
    assign w_raw     = r_f3[2] ? w_div_res : w_mul_res;

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN) && !flush;
    assign result = done ? w_fin : r_result;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && !flush) w_next = func3[2] ? S_DIVCHK : S_MUL;
            S_MUL:    if (r_cnt == '0) w_next = S_FIN;
            S_DIVCHK: w_next = w_special ? S_FIN : S_DIV;
            S_DIV:    if (r_cnt == '0) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (flush && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_div    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef MULDIV_WORD_EN
            r_word   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start && !flush) begin
                    r_f3  <= w_f3_in;
                    r_a   <= w_a_in;
                    r_b   <= w_b_in;
                    r_cnt <= CW'(MUL_STAGES - 1);
`ifdef MULDIV_WORD_EN
                    r_word <= op_w;
`endif
                end
                S_MUL: r_cnt <= r_cnt - CW'(1);
                // Special cases are staged as an unsigned quotient/remainder so FIN needs no extra mux.
                S_DIVCHK: if (w_special) begin
                    r_q    <= w_bzero ? '1 : r_a;
                    r_rem  <= w_bzero ? r_a : '0;
                    r_negq <= 1'b0;
                    r_negr <= 1'b0;
                end else begin
                    r_q    <= w_dvd;
                    r_rem  <= '0;
                    r_div  <= w_abs_b;
                    r_negq <= w_a_neg ^ w_b_neg;
                    r_negr <= w_a_neg;
                    r_cnt  <= w_div_last;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIN: if (!flush) r_result <= w_fin;
                default: ;
            endcase
        end
    end
endmodule
